// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit flag ALU and its result stage.
//   - opcode encodings (ADD..POW)
//   - alu_flags_t : packed {s, z, p, v}
//   - alu_entry_t : packed {data, op, flags}, one buffered ALU result
//   - mask_flags  : clears the flags that are undefined for an opcode
package alu_pkg;

  localparam int unsigned AluWidth = 16;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpSl  = 3'b010;
  localparam logic [2:0] OpSr  = 3'b011;
  localparam logic [2:0] OpOr  = 3'b100;
  localparam logic [2:0] OpAnd = 3'b101;
  localparam logic [2:0] OpXor = 3'b110;
  localparam logic [2:0] OpPow = 3'b111;

  typedef struct packed {
    logic s;
    logic z;
    logic p;
    logic v;
  } alu_flags_t;

  typedef struct packed {
    logic [AluWidth-1:0] data;
    logic [2:0]          op;
    alu_flags_t          flags;
  } alu_entry_t;

  // Sign is only meaningful for ADD/SUB and overflow only for ADD; anything else is forced
  // to 0. The ternaries select a constant whenever the flag is undefined, so an X on the
  // raw Sign/Overflow inputs never reaches storage.
  function automatic alu_flags_t mask_flags(input logic [2:0] op, input logic sign,
                                            input logic zero, input logic parity,
                                            input logic overflow);
    alu_flags_t f;
    f.s = (op[2:1] == 2'b00) ? sign : 1'b0;
    f.z = zero;
    f.p = parity;
    f.v = (op == OpAdd) ? overflow : 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous FIFO of alu_entry_t.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write request and entry (ignored when full)
//   pop           : read request (ignored when empty)
//   rdata         : head entry
//   full, empty   : occupancy status
//   count         : number of stored entries
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  alu_entry_t                   wdata,
  input  logic                         pop,
  output alu_entry_t                   rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  alu_entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [CntW-1:0]       count_q;
  logic                  do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  // Storage is reset too, so the head reads as all-zero straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result/flag capture stage downstream of the 16-bit flag ALU.
// Masks undefined flags per opcode, buffers entries in a FIFO and hands them to the
// writeback consumer with valid/ready.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   In_valid / In_ready           : upstream handshake (In_ready = !full, 0 in reset)
//   Alu_out, Op                   : ALU result and opcode
//   Sign, Zero, Parity, Overflow  : raw ALU flags (Sign/Overflow may be X)
//   Res_valid / Res_ready         : downstream handshake
//   Res_data, Res_op, Res_flags   : head entry, flags as {S,Z,P,V}
//   Count                         : FIFO occupancy
//   Sticky, Sticky_clr            : accumulated flags and their clear
// Configuration: define STICKY_FLAGS_EN to build the sticky register; otherwise Sticky is
// tied to 0 and Sticky_clr is ignored.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = AluWidth  // must match the package entry width
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         In_valid,
  output logic                         In_ready,
  input  logic [WIDTH-1:0]             Alu_out,
  input  logic [2:0]                   Op,
  input  logic                         Sign,
  input  logic                         Zero,
  input  logic                         Parity,
  input  logic                         Overflow,
  output logic                         Res_valid,
  input  logic                         Res_ready,
  output logic [WIDTH-1:0]             Res_data,
  output logic [2:0]                   Res_op,
  output logic [3:0]                   Res_flags,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic [3:0]                   Sticky,
  input  logic                         Sticky_clr
);

  alu_flags_t masked;
  alu_entry_t wentry, head;
  logic       full, empty, push, pop;
  logic       out_of_reset_q;

  // Holds In_ready low during reset and for the reset cycle itself.
  always_ff @(posedge clk) begin
    if (rst) out_of_reset_q <= 1'b0;
    else     out_of_reset_q <= 1'b1;
  end

  assign masked = mask_flags(Op, Sign, Zero, Parity, Overflow);
  assign wentry = '{data: Alu_out, op: Op, flags: masked};

  assign In_ready  = out_of_reset_q && !full;
  assign Res_valid = !empty;
  assign push      = In_valid && In_ready;
  assign pop       = Res_valid && Res_ready;

  alu_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (Count)
  );

  assign Res_data  = head.data;
  assign Res_op    = head.op;
  assign Res_flags = head.flags;

`ifdef STICKY_FLAGS_EN
  logic [3:0] sticky_q;

  // A clear coincident with a push restarts accumulation from the pushed flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else if (Sticky_clr) begin
      sticky_q <= push ? masked : 4'b0000;
    end else if (push) begin
      sticky_q <= sticky_q | masked;
    end
  end

  assign Sticky = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = Sticky_clr;
  assign Sticky            = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (DEPTH=4, WIDTH=16).
module tb_alu_result_stage;
  import alu_pkg::*;

`ifdef STICKY_FLAGS_EN
  localparam bit StickyOn = 1'b1;
`else
  localparam bit StickyOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        In_valid, In_ready;
  logic [15:0] Alu_out;
  logic [2:0]  Op;
  logic        Sign, Zero, Parity, Overflow;
  logic        Res_valid, Res_ready;
  logic [15:0] Res_data;
  logic [2:0]  Res_op;
  logic [3:0]  Res_flags;
  logic [2:0]  Count;
  logic [3:0]  Sticky;
  logic        Sticky_clr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_result_stage #(
    .DEPTH (4),
    .WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .In_valid   (In_valid),
    .In_ready   (In_ready),
    .Alu_out    (Alu_out),
    .Op         (Op),
    .Sign       (Sign),
    .Zero       (Zero),
    .Parity     (Parity),
    .Overflow   (Overflow),
    .Res_valid  (Res_valid),
    .Res_ready  (Res_ready),
    .Res_data   (Res_data),
    .Res_op     (Res_op),
    .Res_flags  (Res_flags),
    .Count      (Count),
    .Sticky     (Sticky),
    .Sticky_clr (Sticky_clr)
  );

  // Advance one clock; outputs are looked at 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] d,
                       input logic s, input logic z, input logic p, input logic o);
    In_valid = v; Op = op; Alu_out = d; Sign = s; Zero = z; Parity = p; Overflow = o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++; if (Res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", Res_valid); end
    n_vec++; if (Res_data !== 16'h0) begin n_err++; $display("FAIL reset_data got %h want 0000", Res_data); end
    n_vec++; if ({Res_op, Res_flags} !== 7'h0) begin n_err++; $display("FAIL reset_op_flags got %b want 0", {Res_op, Res_flags}); end
    n_vec++; if (Count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", Count); end
    n_vec++; if (Sticky !== 4'b0) begin n_err++; $display("FAIL reset_sticky got %b want 0000", Sticky); end
    n_vec++; if (In_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", In_ready); end
    rst = 1'b0;
    tick();
    n_vec++; if (In_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", In_ready); end
  endtask

  task automatic test_sticky();
    logic [3:0] exp1, exp3;
    exp1 = StickyOn ? 4'b0100 : 4'b0000;
    exp3 = StickyOn ? 4'b1000 : 4'b0000;
    Res_ready = 1'b0;
    drive(1'b1, OpAdd, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    n_vec++; if (Sticky !== exp1) begin n_err++; $display("FAIL sticky_add got %b want %b", Sticky, exp1); end
    drive(1'b1, OpXor, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_vec++; if (Sticky !== exp1) begin n_err++; $display("FAIL sticky_xor got %b want %b", Sticky, exp1); end
    drive(1'b1, OpSub, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    Sticky_clr = 1'b1;
    tick();
    Sticky_clr = 1'b0;
    In_valid   = 1'b0;
    n_vec++; if (Sticky !== exp3) begin n_err++; $display("FAIL sticky_clr_push got %b want %b", Sticky, exp3); end
    n_vec++; if (Count !== 3'd3) begin n_err++; $display("FAIL sticky_count got %0d want 3", Count); end
    // Drain: ADD/Z, XOR, SUB with S kept and V dropped.
    Res_ready = 1'b1;
    n_vec++; if ({Res_data, Res_flags} !== {16'h0000, 4'b0100}) begin n_err++; $display("FAIL drain_add got %h/%b want 0000/0100", Res_data, Res_flags); end
    tick();
    n_vec++; if ({Res_data, Res_op} !== {16'h0003, OpXor}) begin n_err++; $display("FAIL drain_xor got %h/%b want 0003/110", Res_data, Res_op); end
    tick();
    n_vec++; if ({Res_data, Res_flags} !== {16'hFFFF, 4'b1000}) begin n_err++; $display("FAIL drain_sub got %h/%b want ffff/1000", Res_data, Res_flags); end
    tick();
    Res_ready = 1'b0;
    n_vec++; if (Res_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b want 0", Res_valid); end
  endtask

  task automatic test_add_flags();
    Res_ready = 1'b0;
    drive(1'b1, OpAdd, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    In_valid = 1'b0;
    n_vec++; if (Res_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b want 1", Res_valid); end
    n_vec++; if (Res_data !== 16'h8000) begin n_err++; $display("FAIL add_data got %h want 8000", Res_data); end
    n_vec++; if (Res_flags !== 4'b1001) begin n_err++; $display("FAIL add_flags got %b want 1001", Res_flags); end
    tick();
    n_vec++; if (Res_data !== 16'h8000 || Res_valid !== 1'b1) begin n_err++; $display("FAIL add_hold got %h/%b want 8000/1", Res_data, Res_valid); end
    Res_ready = 1'b1;
    tick();
    Res_ready = 1'b0;
    n_vec++; if (Count !== 3'd0) begin n_err++; $display("FAIL add_pop_count got %0d want 0", Count); end
  endtask

  task automatic test_or_x();
    logic [3:0] exp_sticky;
    logic       xr;
    drive(1'b1, OpOr, 16'h0001, 1'bx, 1'b0, 1'b0, 1'bx);
    tick();
    In_valid = 1'b0; Sign = 1'b0; Overflow = 1'b0;
    exp_sticky = StickyOn ? 4'b1001 : 4'b0000;  // accumulated from the ADD before
    n_vec++; if (Res_flags !== 4'b0000) begin n_err++; $display("FAIL or_flags got %b want 0000", Res_flags); end
    n_vec++; if (Sticky !== exp_sticky) begin n_err++; $display("FAIL or_sticky got %b want %b", Sticky, exp_sticky); end
    xr = ^{In_ready, Res_valid, Res_data, Res_op, Res_flags, Count, Sticky};
    n_vec++; if (xr === 1'bx) begin n_err++; $display("FAIL or_no_x got %b want 0/1", xr); end
    Res_ready = 1'b1;
    tick();
    Res_ready = 1'b0;
  endtask

  task automatic test_full_wrap();
    int got;
    Res_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, OpAdd, 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, OpAdd, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_vec++; if (Count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", Count); end
    n_vec++; if (In_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b want 0", In_ready); end
    n_vec++; if (Res_data !== 16'd1) begin n_err++; $display("FAIL full_head got %h want 0001", Res_data); end
    Res_ready = 1'b1;
    got = 1;
    for (int cyc = 0; cyc < 20 && got <= 5; cyc++) begin
      if (Res_valid === 1'b1) begin
        n_vec++; if (Res_data !== 16'(got)) begin n_err++; $display("FAIL wrap_order got %h want %h", Res_data, 16'(got)); end
        got++;
      end
      if (In_valid && In_ready) begin
        tick();
        In_valid = 1'b0;
      end else begin
        tick();
      end
    end
    n_vec++; if (got != 6) begin n_err++; $display("FAIL wrap_drain_timeout got %0d want 6", got); end
    Res_ready = 1'b0;
    In_valid  = 1'b0;
    n_vec++; if (Count !== 3'd0) begin n_err++; $display("FAIL wrap_count got %0d want 0", Count); end
  endtask

  task automatic test_back_to_back();
    Res_ready = 1'b0;
    drive(1'b1, OpAnd, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, OpAnd, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_vec++; if (Count !== 3'd2) begin n_err++; $display("FAIL b2b_pre_count got %0d want 2", Count); end
    drive(1'b1, OpAnd, 16'h000C, 1'b0, 1'b0, 1'b1, 1'b0);
    Res_ready = 1'b1;
    tick();
    In_valid = 1'b0;
    n_vec++; if (Count !== 3'd2) begin n_err++; $display("FAIL b2b_count got %0d want 2", Count); end
    n_vec++; if (Res_data !== 16'h000B) begin n_err++; $display("FAIL b2b_head got %h want 000b", Res_data); end
    tick();
    n_vec++; if ({Res_data, Res_flags} !== {16'h000C, 4'b0010}) begin n_err++; $display("FAIL b2b_tail got %h/%b want 000c/0010", Res_data, Res_flags); end
    tick();
    Res_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    Res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OpAdd, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
    end
    n_vec++; if (Count !== 3'd3) begin n_err++; $display("FAIL mid_pre_count got %0d want 3", Count); end
    rst = 1'b1;  // coincident push is lost
    tick();
    rst = 1'b0;
    In_valid = 1'b0;
    n_vec++; if (Count !== 3'd0) begin n_err++; $display("FAIL mid_count got %0d want 0", Count); end
    n_vec++; if (Res_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", Res_valid); end
    n_vec++; if (Sticky !== 4'b0) begin n_err++; $display("FAIL mid_sticky got %b want 0000", Sticky); end
    n_vec++; if (In_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready_rst got %b want 0", In_ready); end
    tick();
    n_vec++; if (In_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready_after got %b want 1", In_ready); end
    n_vec++; if (Count !== 3'd0) begin n_err++; $display("FAIL mid_count_after got %0d want 0", Count); end
  endtask

  initial begin
    rst = 1'b1; Res_ready = 1'b0; Sticky_clr = 1'b0;
    drive(1'b0, OpAdd, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_sticky();
    test_add_flags();
    test_or_x();
    test_full_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
